// File: rtl/control_pkg.sv
// Shared types and decode constants for the control sequencer.
// Encodings here are what the datapath sees on alu_op.
package control_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEC  = 3'd1,
        ALU  = 3'd2,
        WR   = 3'd3,
        ILL  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_SLT    = 3'd5,
        ALU_PASS_B = 3'd6
    } alu_op_t;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/control_unit_if.sv
// Instruction handshake in, datapath control bundle out.
// master = fetch/environment side, slave = control unit side.
interface control_unit_if #(
    parameter int LENGTH   = 32,
    parameter int SEL_BITS = 5
);
    logic [LENGTH-1:0]   instr;
    logic                instr_valid;
    logic                instr_ready;
    logic [SEL_BITS-1:0] addr_a;
    logic [SEL_BITS-1:0] addr_b;
    logic [SEL_BITS-1:0] addr_d;
    logic                wr_regfile;
    logic [LENGTH-1:0]   imm;
    logic                f;
    logic [2:0]          alu_op;
    logic                illegal;

    modport master (
        output instr, instr_valid,
        input  instr_ready, addr_a, addr_b, addr_d, wr_regfile, imm, f, alu_op, illegal
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, addr_a, addr_b, addr_d, wr_regfile, imm, f, alu_op, illegal
    );
endinterface

// File: rtl/control_unit_imm_gen.sv
// Purpose: builds the U-type or sign-extended I-type immediate from an instruction.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module imm_gen #(
    parameter int LENGTH = 32
) (
    input  logic [LENGTH-1:0] instr,
    input  logic              is_u,
    output logic [LENGTH-1:0] imm
);
    always_comb begin
        if (is_u) begin
            imm = {instr[31:12], 12'b0};
        end else begin
            imm = {{20{instr[31]}}, instr[31:20]};
        end
    end
endmodule

// File: rtl/control_unit.sv
// Purpose: decodes one RV32I-subset instruction and sequences the datapath DEC -> ALU -> WR.
// Latency: wr_regfile pulses in the third cycle after accept; one instruction per 4 cycles.
// Backpressure: instr_ready is high only in IDLE; instr_valid elsewhere is ignored.
module control_unit
    import control_pkg::*;
#(
    parameter int LENGTH   = 32,
    parameter int NREGS    = 32,
    parameter int SEL_BITS = $clog2(NREGS)
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.slave  bus
);
    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    logic       legal, is_u, dec_f, zero_ab, accept;
    alu_op_t    dec_op;
    logic [LENGTH-1:0] gen_imm;

    logic [SEL_BITS-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_d_q, addr_d_d;
    logic [LENGTH-1:0]   imm_q, imm_d;
    logic                f_q, f_d, wr_regfile_q, wr_regfile_d, illegal_q, illegal_d;
    alu_op_t             alu_op_q, alu_op_d;

    assign opcode = bus.instr[6:0];
    assign rd     = bus.instr[11:7];
    assign funct3 = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign funct7 = bus.instr[31:25];
    assign accept = bus.instr_valid && (state_q == IDLE);

    imm_gen #(.LENGTH(LENGTH)) u_imm_gen (
        .instr (bus.instr),
        .is_u  (is_u),
        .imm   (gen_imm)
    );

    always_comb begin
        legal   = 1'b0;
        is_u    = 1'b0;
        dec_f   = 1'b0;
        zero_ab = 1'b0;
        dec_op  = ALU_ADD;
        unique case (opcode)
            OPC_LUI: begin
                legal   = 1'b1;
                is_u    = 1'b1;
                dec_f   = 1'b1;
                zero_ab = 1'b1;
                dec_op  = ALU_PASS_B;
            end
            OPC_OPIMM: begin
                legal = (funct3 == F3_ADD);
                dec_f = 1'b1;
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    unique case (funct3)
                        F3_ADD:  dec_op = ALU_ADD;
                        F3_AND:  dec_op = ALU_AND;
                        F3_OR:   dec_op = ALU_OR;
                        F3_XOR:  dec_op = ALU_XOR;
                        F3_SLT:  dec_op = ALU_SLT;
                        default: legal  = 1'b0;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
                    legal  = 1'b1;
                    dec_op = ALU_SUB;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = legal ? DEC : ILL;
            DEC:     state_d = ALU;
            ALU:     state_d = WR;
            WR:      state_d = IDLE;
            ILL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode fields are captured only on a legal accept and otherwise hold.
    always_comb begin
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        addr_d_d     = addr_d_q;
        imm_d        = imm_q;
        f_d          = f_q;
        alu_op_d     = alu_op_q;
        wr_regfile_d = (state_q == ALU);
        illegal_d    = accept && !legal;
        if (accept && legal) begin
            addr_a_d = zero_ab ? '0 : rs1[SEL_BITS-1:0];
            addr_b_d = zero_ab ? '0 : rs2[SEL_BITS-1:0];
            addr_d_d = rd[SEL_BITS-1:0];
            imm_d    = dec_f ? gen_imm : '0;
            f_d      = dec_f;
            alu_op_d = dec_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            addr_d_q     <= '0;
            imm_q        <= '0;
            f_q          <= 1'b0;
            alu_op_q     <= ALU_ADD;
            wr_regfile_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            addr_d_q     <= addr_d_d;
            imm_q        <= imm_d;
            f_q          <= f_d;
            alu_op_q     <= alu_op_d;
            wr_regfile_q <= wr_regfile_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.addr_a      = addr_a_q;
    assign bus.addr_b      = addr_b_q;
    assign bus.addr_d      = addr_d_q;
    assign bus.imm         = imm_q;
    assign bus.f           = f_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.wr_regfile  = wr_regfile_q;
    assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_control_unit.sv
// Purpose: self-checking bench for control_unit using a vector table and a scoreboard queue.
// Latency: checks the 4-cycle legal and 2-cycle illegal sequences edge by edge.
// Backpressure: waits (bounded) for instr_ready before each accept.
module tb_control_unit;

    typedef struct {
        logic [31:0] instr;
        bit          legal;
        bit          keep;
        logic [4:0]  a, b, d;
        logic [31:0] imm;
        bit          f;
        logic [2:0]  op;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    vec_t vt[13];
    vec_t sb[$];
    vec_t last;
    bit   prev_keep = 1'b0;
    int   prev_acc  = 0;

    control_unit_if #(.LENGTH(32), .SEL_BITS(5)) bus ();

    control_unit #(.LENGTH(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(logic [31:0] ins, bit lg, bit kp, logic [4:0] a, logic [4:0] b,
                                logic [4:0] d, logic [31:0] im, bit ff, logic [2:0] op);
        vec_t v;
        v.instr = ins; v.legal = lg; v.keep = kp;
        v.a = a; v.b = b; v.d = d; v.imm = im; v.f = ff; v.op = op;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_fields(string tag, vec_t e);
        check({tag, ".addr_a"}, {27'b0, bus.addr_a}, {27'b0, e.a});
        check({tag, ".addr_b"}, {27'b0, bus.addr_b}, {27'b0, e.b});
        check({tag, ".addr_d"}, {27'b0, bus.addr_d}, {27'b0, e.d});
        check({tag, ".imm"}, bus.imm, e.imm);
        check({tag, ".f"}, {31'b0, bus.f}, {31'b0, e.f});
        check({tag, ".alu_op"}, {29'b0, bus.alu_op}, {29'b0, e.op});
    endtask

    task automatic run_vec(vec_t v, int idx);
        vec_t e;
        int   g = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        bus.instr       = v.instr;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 20) begin
            check({tag, ".ready_timeout"}, 32'd0, 32'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        e = v;
        if (!v.legal) begin
            e.a = last.a; e.b = last.b; e.d = last.d;
            e.imm = last.imm; e.f = last.f; e.op = last.op;
        end else begin
            last = v;
        end
        sb.push_back(e);

        @(posedge clk); #1;
        if (prev_keep) check({tag, ".accept_spacing"}, cyc - prev_acc, 32'd4);
        prev_acc  = cyc;
        prev_keep = v.keep;
        if (!v.keep) bus.instr_valid = 1'b0;
        check({tag, ".ready_n1"}, {31'b0, bus.instr_ready}, 32'd0);
        check({tag, ".wr_n1"}, {31'b0, bus.wr_regfile}, 32'd0);
        check({tag, ".illegal_n1"}, {31'b0, bus.illegal}, {31'b0, !v.legal});

        if (v.legal) begin
            check_fields({tag, ".dec"}, v);
            @(posedge clk); #1;
            check({tag, ".wr_n2"}, {31'b0, bus.wr_regfile}, 32'd0);
            check({tag, ".ready_n2"}, {31'b0, bus.instr_ready}, 32'd0);
            @(posedge clk); #1;
            check({tag, ".wr_n3"}, {31'b0, bus.wr_regfile}, 32'd1);
            check({tag, ".ready_n3"}, {31'b0, bus.instr_ready}, 32'd0);
        end
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_fields({tag, ".sb"}, e);
        end
        @(posedge clk); #1;
        check({tag, ".wr_end"}, {31'b0, bus.wr_regfile}, 32'd0);
        check({tag, ".illegal_end"}, {31'b0, bus.illegal}, 32'd0);
        check({tag, ".ready_end"}, {31'b0, bus.instr_ready}, 32'd1);
    endtask

    initial begin
        vec_t zero_v;
        vt[0]  = mk(32'hCAC00037, 1, 0, 5'd0, 5'd0, 5'd0, 32'hCAC00000, 1, 3'd6);
        vt[1]  = mk(32'h010000B7, 1, 1, 5'd0, 5'd0, 5'd1, 32'h01000000, 1, 3'd6);
        vt[2]  = mk(32'h00100133, 1, 0, 5'd0, 5'd1, 5'd2, 32'h00000000, 0, 3'd0);
        vt[3]  = mk(32'hFFF08193, 1, 0, 5'd1, 5'd31, 5'd3, 32'hFFFFFFFF, 1, 3'd0);
        vt[4]  = mk(32'h40110233, 1, 0, 5'd2, 5'd1, 5'd4, 32'h00000000, 0, 3'd1);
        vt[5]  = mk(32'h00000000, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 3'd0);
        vt[6]  = mk(32'h0020F2B3, 1, 0, 5'd1, 5'd2, 5'd5, 32'h00000000, 0, 3'd2);
        vt[7]  = mk(32'h0020E2B3, 1, 0, 5'd1, 5'd2, 5'd5, 32'h00000000, 0, 3'd3);
        vt[8]  = mk(32'h0020C2B3, 1, 0, 5'd1, 5'd2, 5'd5, 32'h00000000, 0, 3'd4);
        vt[9]  = mk(32'h0020A2B3, 1, 0, 5'd1, 5'd2, 5'd5, 32'h00000000, 0, 3'd5);
        vt[10] = mk(32'h4020F2B3, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 3'd0);
        vt[11] = mk(32'h00109093, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 3'd0);
        vt[12] = mk(32'h0000006F, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 3'd0);
        zero_v = mk(32'h0, 1, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 3'd0);
        last   = zero_v;

        // Reset held with a valid instruction present: nothing may be accepted.
        reset           = 1'b0;
        bus.instr       = 32'hCAC00037;
        bus.instr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", {31'b0, bus.instr_ready}, 32'd1);
        check("rst.wr", {31'b0, bus.wr_regfile}, 32'd0);
        check("rst.illegal", {31'b0, bus.illegal}, 32'd0);
        check_fields("rst", zero_v);
        bus.instr_valid = 1'b0;
        reset           = 1'b1;
        @(posedge clk); #1;
        check("post_rst.ready", {31'b0, bus.instr_ready}, 32'd1);
        check_fields("post_rst", zero_v);

        for (int i = 0; i < 13; i++) run_vec(vt[i], i);

        // Reset during the ALU cycle must abort with no write pulse.
        bus.instr       = 32'h00100133;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        check("abort.ready_dec", {31'b0, bus.instr_ready}, 32'd0);
        @(posedge clk); #1;
        check("abort.ready_alu", {31'b0, bus.instr_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort.ready", {31'b0, bus.instr_ready}, 32'd1);
        check("abort.wr", {31'b0, bus.wr_regfile}, 32'd0);
        check_fields("abort", zero_v);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort.wr_after", {31'b0, bus.wr_regfile}, 32'd0);
        check("abort.ready_after", {31'b0, bus.instr_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle control sequencer that drives the `datapath` control interface: addr_a, addr_b, addr_d, wr_regfile, imm and f, plus alu_op.
- Accepts one 32-bit RV32I-subset instruction per valid/ready handshake.
- Decodes the instruction and steps the datapath through DEC -> ALU -> WR.
- Sits between instruction fetch and `datapath`; it is the producer of exactly the signals `datapath` consumes.

Parameters:
- LENGTH, 32, data/instruction width; decode is defined for 32 only.
- NREGS, 32, number of architectural registers.
- SEL_BITS, $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- instr  in  LENGTH  instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  unit can accept an instruction.
- addr_a  out  SEL_BITS  rs1 register address.
- addr_b  out  SEL_BITS  rs2 register address.
- addr_d  out  SEL_BITS  rd register address.
- wr_regfile  out  1  register file write enable.
- imm  out  LENGTH  immediate operand.
- f  out  1  operand-B select; 1 = imm, 0 = register b.
- alu_op  out  3  ALU function.
- illegal  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- **Reset:** reset==0 at a rising edge puts the FSM in IDLE. All outputs are 0 except instr_ready, which is 1. Reset mid-instruction aborts it; no write occurs on or after that edge.
- **FSM states:** IDLE, DEC, ALU, WR, ILL. All outputs are registered except instr_ready, which equals (state==IDLE).
- **Accept:** a handshake is instr_valid && instr_ready at an edge, edge N.
- **Legal instruction timing:**
  - Edge N: decoded fields are registered into addr_a/addr_b/addr_d/imm/f/alu_op; state -> DEC.
  - Edge N+1: state -> ALU.
  - Edge N+2: state -> WR; wr_regfile=1 for exactly this cycle.
  - Edge N+3: state -> IDLE; wr_regfile=0.
  - Throughput is one instruction per 4 cycles. The next accept can occur at edge N+4 at the earliest.
- **Output hold:** addr_*, imm, f and alu_op stay stable from DEC through WR, and hold their last values in IDLE and ILL.
- **Illegal instruction:** edge N -> ILL with illegal=1 for one cycle; decode outputs are unchanged and wr_regfile stays 0. The next edge -> IDLE.
- **instr_valid outside IDLE:** ignored; instr is not sampled.
- **Register 0:** rd==0 is written normally. Any x0 semantics are the register file's responsibility.
- **Decode**, opcode = instr[6:0]:
  - LUI, 0110111: imm={instr[31:12],12'b0}; f=1; alu_op=PASS_B; addr_d=instr[11:7]; addr_a=addr_b=0.
  - OP-IMM, 0010011, funct3==000 (ADDI): imm = sign-extended instr[31:20]; f=1; alu_op=ADD.
  - OP, 0110011, f=1'b0 and imm=0:
    - funct7=0000000: funct3 000=ADD, 111=AND, 110=OR, 100=XOR, 010=SLT.
    - funct7=0100000 with funct3 000: SUB.
  - Any other opcode, funct3 or funct7 combination is illegal.
- **Address fields:** addr_a=instr[19:15], addr_b=instr[24:20], addr_d=instr[11:7], each truncated to SEL_BITS.
- **alu_op encoding:** ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, PASS_B=6; 7 is reserved and never driven.

Decomposition:
- Package `control_pkg`:
  - state_t enum (IDLE, DEC, ALU, WR, ILL).
  - alu_op_t enum with the encoding above.
  - Opcode constants OPC_LUI, OPC_OPIMM, OPC_OP.
  - Funct3/funct7 constants.
- Sub-module `imm_gen`: combinational; instr in, imm and an is_u/is_i selector, producing the U- and I-type immediates. The rest of the decode and the FSM stay in control_unit.

Test Plan:
- Reset held low for 2 cycles while instr_valid=1 -> instr_ready=1, wr_regfile=0, all other outputs 0, no accept.
- instr=0xCAC00037 (LUI x0) accepted at edge N -> at N+1: addr_d=0, imm=0xCAC00000, f=1, alu_op=6. wr_regfile=1 only in the cycle after edge N+2. instr_ready=0 from N+1 to N+3.
- Back-to-back sequence, instr_valid held high:
  - 0x010000B7 (LUI x1) -> imm=0x01000000, addr_d=1.
  - 0x00100133 (ADD x2,x0,x1) -> addr_a=0, addr_b=1, addr_d=2, f=0, alu_op=0.
  - Accepts occur exactly 4 cycles apart.
- instr=0xFFF08193 (ADDI x3,x1,-1) -> imm=0xFFFFFFFF, f=1, addr_a=1, addr_d=3, alu_op=0.
- instr=0x40110233 (SUB x4,x2,x1) -> alu_op=1, addr_a=2, addr_b=1, addr_d=4.
- instr=0x00000000 -> illegal=1 for one cycle, wr_regfile never set, instr_ready=1 again two cycles after accept.
- Reset asserted in the ALU cycle of an ADD -> next cycle IDLE, and no wr_regfile pulse.
